// File: rtl/fip_mac_pipe_if.sv
// fip_mac_pipe_if: valid/ready stream bundle for the fixed-point MAC pipeline.
interface fip_mac_pipe_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         acc_en;
  logic         last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  modport master (output in_valid, x, y, acc_en, last, out_ready, input in_ready, out_valid, result, overflow);
  modport slave (input in_valid, x, y, acc_en, last, out_ready, output in_ready, out_valid, result, overflow);
endinterface

// File: rtl/fip_mac_pipe.sv
// fip_mac_pipe: 3-stage signed Q(INT.FRAC) multiply / multiply-accumulate, round-half-up.
// Define FIP_SAT_EN to clamp out-of-range results instead of wrapping.
module fip_mac_pipe #(
  parameter int INT_BITS   = 16,
  parameter int FRAC_BITS  = 16,
  parameter int GUARD_BITS = 8
) (
  input logic clk,
  input logic rst_n,
  fip_mac_pipe_if.slave bus
);
  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int AW = W + GUARD_BITS;
  localparam int SW = 2 * W + GUARD_BITS + 1;
`ifdef FIP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic signed [SW-1:0] WMAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] WMIN = ~WMAX;
  localparam logic signed [SW-1:0] AMAX = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] AMIN = ~AMAX;
  localparam logic signed [2*W-1:0] HALF = {{(2*W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  logic                   en, v1, a1, l1, v2, a2, l2, sticky, pov, aov, sov;
  logic signed [W-1:0]    x1, y1;
  logic signed [2*W-1:0]  prod, p2;
  logic signed [AW-1:0]   acc, asat;
  logic signed [SW-1:0]   pe, sum;

  function automatic logic [W-1:0] fmt(input logic signed [SW-1:0] v);
    return (SAT && v > WMAX) ? WMAX[W-1:0] : (SAT && v < WMIN) ? WMIN[W-1:0] : v[W-1:0];
  endfunction

  assign en = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = en;

  always_comb begin
    prod = $signed({{W{x1[W-1]}}, x1} * {{W{y1[W-1]}}, y1}) + HALF;
    pe   = {{(SW-2*W){p2[2*W-1]}}, p2};
    sum  = pe + {{(SW-AW){acc[AW-1]}}, acc};
    pov  = pe > WMAX || pe < WMIN;
    aov  = sum > AMAX || sum < AMIN;
    sov  = sum > WMAX || sum < WMIN;
    asat = sum > AMAX ? AMAX[AW-1:0] : sum < AMIN ? AMIN[AW-1:0] : sum[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= 1'b0;
      l1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      v2 <= 1'b0;
      a2 <= 1'b0;
      l2 <= 1'b0;
      p2 <= '0;
      acc <= '0;
      sticky <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result <= '0;
      bus.overflow <= 1'b0;
    end else if (en) begin
      v1 <= bus.in_valid;
      a1 <= bus.acc_en;
      l1 <= bus.last;
      x1 <= bus.x;
      y1 <= bus.y;
      v2 <= v1;
      a2 <= a1;
      l2 <= l1;
      p2 <= prod >>> FRAC_BITS;
      bus.out_valid <= v2 & (~a2 | l2);
      // plain beats bypass the accumulator so an open sum survives interleaving
      if (v2 && !a2) begin
        bus.result <= fmt(pe);
        bus.overflow <= pov;
      end else if (v2 && l2) begin
        bus.result <= fmt(sum);
        bus.overflow <= sticky | pov | aov | sov;
        acc <= '0;
        sticky <= 1'b0;
      end else if (v2) begin
        acc <= asat;
        sticky <= sticky | pov | aov;
      end
    end
endmodule

// File: tb/tb_fip_mac_pipe.sv
// tb_fip_mac_pipe: table-driven vectors with a scoreboard queue, plus latency, backpressure and reset sequences.
module tb_fip_mac_pipe;
`ifdef FIP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        ae;
    logic        l;
    logic [31:0] r;
    logic        o;
  } vec_t;
  typedef struct {
    logic [31:0] r;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t exq[$];
  vec_t tv[26];
  logic held_seen = 1'b0;
  logic [32:0] held_val;

  fip_mac_pipe_if #(.W(32)) bus ();
  fip_mac_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ae, input logic l,
                      input logic [31:0] er, input logic eo);
    logic ok;
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.acc_en = ae;
    bus.last = l;
    if (!ae || l) exq.push_back('{r: er, o: eo});
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      t++;
      if (t > 100) begin
        check("accept_timeout", 33'd1, 33'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) if (rst_n) begin
    if (bus.out_valid && !bus.out_ready) begin
      check("in_ready_held", {32'd0, bus.in_ready}, 33'd0);
      if (held_seen) check("held_stable", {bus.overflow, bus.result}, held_val);
      held_seen = 1'b1;
      held_val = {bus.overflow, bus.result};
    end else held_seen = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      if (exq.size() == 0) check("unexpected_out", {bus.overflow, bus.result}, 33'h1_DEAD_BEEF);
      else begin
        exp_t e;
        e = exq.pop_front();
        check("result", {bus.overflow, bus.result}, {e.o, e.r});
      end
    end
  end

  initial begin
    int cnt;
    tv[0]  = '{32'h00018000, 32'h00020000, 0, 0, 32'h00030000, 0};
    tv[1]  = '{32'h00000001, 32'h00008000, 0, 0, 32'h00000001, 0};
    tv[2]  = '{32'hFFFFFFFF, 32'h00008000, 0, 0, 32'h00000000, 0};
    tv[3]  = '{32'h00000003, 32'h00008000, 0, 0, 32'h00000002, 0};
    tv[4]  = '{32'hFFFFFFFD, 32'h00008000, 0, 0, 32'hFFFFFFFF, 0};
    tv[5]  = '{32'h7FFF0000, 32'h00020000, 0, 0, SAT ? 32'h7FFFFFFF : 32'hFFFE0000, 1};
    tv[6]  = '{32'hFFFE8000, 32'h00020000, 0, 0, 32'hFFFD0000, 0};
    tv[7]  = '{32'h80000000, 32'h00010000, 0, 0, 32'h80000000, 0};
    tv[8]  = '{32'h7FFFFFFF, 32'h00010000, 0, 0, 32'h7FFFFFFF, 0};
    tv[9]  = '{32'h80000000, 32'hFFFF0000, 0, 0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1};
    tv[10] = '{32'h80000000, 32'h80000000, 0, 0, SAT ? 32'h7FFFFFFF : 32'h00000000, 1};
    tv[11] = '{32'h00010000, 32'h00010000, 1, 0, 32'h0, 0};
    tv[12] = '{32'h00020000, 32'h00008000, 1, 0, 32'h0, 0};
    tv[13] = '{32'hFFFF8000, 32'h00010000, 1, 1, 32'h00018000, 0};
    tv[14] = '{32'h00010000, 32'h00010000, 1, 0, 32'h0, 0};
    tv[15] = '{32'h00020000, 32'h00020000, 0, 0, 32'h00040000, 0};
    tv[16] = '{32'h00010000, 32'h00010000, 1, 1, 32'h00020000, 0};
    tv[17] = '{32'h7FFF0000, 32'h00010000, 1, 0, 32'h0, 0};
    tv[18] = '{32'h7FFF0000, 32'h00010000, 1, 0, 32'h0, 0};
    tv[19] = '{32'h00000000, 32'h00000000, 1, 1, SAT ? 32'h7FFFFFFF : 32'hFFFE0000, 1};
    tv[20] = '{32'h7FFF0000, 32'h00020000, 1, 0, 32'h0, 0};
    tv[21] = '{32'h80000000, 32'h00020000, 1, 0, 32'h0, 0};
    tv[22] = '{32'h00000000, 32'h00000000, 1, 1, 32'hFFFE0000, 1};
    tv[23] = '{32'h80000000, 32'h80000000, 1, 0, 32'h0, 0};
    tv[24] = '{32'h00000000, 32'h00000000, 1, 1, SAT ? 32'h7FFFFFFF : 32'hFFFFFFFF, 1};
    tv[25] = '{32'h00018000, 32'h00020000, 1, 1, 32'h00030000, 0};

    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.acc_en = 1'b0;
    bus.last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.out_valid, bus.overflow, bus.in_ready, bus.result[29:0]}, 33'h0_4000_0000 >> 1 << 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency: accept edge counts as the first cycle
    exq.push_back('{r: 32'h00030000, o: 1'b0});
    bus.in_valid = 1'b1;
    bus.x = 32'h00018000;
    bus.y = 32'h00020000;
    bus.acc_en = 1'b0;
    bus.last = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 1;
    while (!bus.out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", 33'(cnt), 33'd3);
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) send(tv[i].x, tv[i].y, tv[i].ae, tv[i].l, tv[i].r, tv[i].o);

    fork
      for (int i = 0; i < 8; i++) send(32'(i + 1) << 16, 32'h00020000, 1'b0, 1'b0, 32'(2 * i + 2) << 16, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join

    repeat (6) @(posedge clk);
    #1;
    send(32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h0, 1'b0);
    send(32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    check("async_reset", {30'd0, bus.out_valid, bus.overflow, bus.in_ready}, 33'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h00010000, 32'h00010000, 1'b1, 1'b1, 32'h00010000, 1'b0);

    cnt = 0;
    while (exq.size() != 0 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain", 33'(exq.size()), 33'd0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
